// File: rtl/count_sequencer.sv
// count_sequencer
//   Start/stop/pause controlled up-counter with a latched terminal count.
//   One-shot mode counts 0..limit once and parks at limit; periodic mode
//   wraps to 0 after limit and keeps running. Every reached terminal count
//   produces a one-cycle done pulse and bumps a saturating period counter.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   single-cycle command: latch limit/mode and begin counting
//   stop     in   abort to IDLE (highest priority)
//   pause    in   level; freezes counting while high
//   mode     in   0 = one-shot, 1 = periodic (sampled with start)
//   limit    in   terminal count (sampled with start, 0 is rejected)
//   q        out  current count
//   busy     out  high in RUN or HOLD
//   done     out  one-cycle pulse per reached terminal count
//   err      out  one-cycle pulse on a rejected start
//   periods  out  completed periods since last accepted start, saturating
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for an accepted start, q keeps last value
// RUN   | counting toward lim_r
// HOLD  | paused, q frozen until pause drops

module count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PCNT_W-1:0] periods
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] lim_r;
    logic             mode_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            q       <= '0;
            lim_r   <= '0;
            mode_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            periods <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (stop) begin
                state <= IDLE;
                q     <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (limit != '0) begin
                                lim_r   <= limit;
                                mode_r  <= mode;
                                q       <= '0;
                                periods <= '0;
                                state   <= RUN;
                                busy    <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    // start is deliberately not decoded here: a running
                    // sequence can only be restarted after a stop.
                    RUN: begin
                        if (pause) begin
                            state <= HOLD;
                        end else if (q == lim_r) begin
                            done <= 1'b1;
                            if (periods != PCNT_MAX)
                                periods <= periods + 1'b1;
                            if (mode_r) begin
                                q <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            q <= q + 1'b1;
                        end
                    end
                    // Resume edge only returns to RUN; counting restarts
                    // on the following edge.
                    HOLD: begin
                        if (!pause)
                            state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Directed scenarios followed by randomized stimulus, all checked
//   against a behavioural model of the counter kept in this bench.

module tb_count_sequencer;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;
    localparam int PMAX   = (1 << PCNT_W) - 1;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic              pause = 1'b0;
    logic              mode  = 1'b0;
    logic [WIDTH-1:0]  limit = '0;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic              done;
    logic              err;
    logic [PCNT_W-1:0] periods;

    count_sequencer #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .mode    (mode),
        .limit   (limit),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .periods (periods)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: "active" means a sequence is in progress,
    // "frozen" means it is paused.
    int m_q, m_lim, m_mode, m_periods;
    bit m_active, m_frozen, m_done, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_lim = 0; m_mode = 0; m_periods = 0;
        m_active = 0; m_frozen = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (!reset) begin
            model_reset();
        end else if (stop) begin
            m_active = 0;
            m_frozen = 0;
            m_q      = 0;
        end else if (!m_active) begin
            if (start) begin
                if (limit != 0) begin
                    m_lim     = int'(limit);
                    m_mode    = int'(mode);
                    m_q       = 0;
                    m_periods = 0;
                    m_active  = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_frozen) begin
            if (!pause) m_frozen = 0;
        end else if (pause) begin
            m_frozen = 1;
        end else if (m_q == m_lim) begin
            m_done = 1;
            if (m_periods < PMAX) m_periods = m_periods + 1;
            if (m_mode == 1) m_q = 0;
            else m_active = 0;
        end else begin
            m_q = m_q + 1;
        end
    endtask

    task automatic compare_all();
        chk("q",       q,       m_q);
        chk("busy",    busy,    m_active);
        chk("done",    done,    m_done);
        chk("err",     err,     m_err);
        chk("periods", periods, m_periods);
    endtask

    // Inputs are changed only 1 time unit after the edge, so the model
    // sees the same input values the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int edges;
        bit seen;

        model_reset();
        #2;
        chk("rst_q",    q,    0);
        chk("rst_busy", busy, 0);
        ticks(2);
        reset = 1'b1;
        tick();

        // One-shot, limit 5; later limit change and start-in-RUN are ignored
        mode = 1'b0; limit = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_q0", q, 0);
        limit = 4'd2;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin start = 1'b1; limit = 4'd0; end
            tick();
            start = 1'b0;
            chk("os_q", q, i);
            chk("os_no_err", err, 0);
        end
        tick();
        chk("os_done", done, 1);
        chk("os_idle", busy, 0);
        chk("os_hold5", q, 5);
        tick();
        chk("os_done_once", done, 0);
        chk("os_q_park", q, 5);

        // Periodic, limit 3, 12 cycles
        mode = 1'b1; limit = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("per_q", q, i % 4);
            chk("per_done", done, (i % 4) == 0);
        end
        chk("per_periods", periods, 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_q", q, 0);
        chk("stop_periods_kept", periods, 3);

        // Pause for 3 cycles at q=2 delays done by 4 edges
        mode = 1'b0; limit = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        ticks(2);
        chk("pz_q2", q, 2);
        pause = 1'b1;
        ticks(3);
        chk("pz_frozen", q, 2);
        chk("pz_busy", busy, 1);
        pause = 1'b0;
        tick();
        chk("pz_resume_no_inc", q, 2);
        tick();
        chk("pz_q3", q, 3);
        edges = 7;
        seen  = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            edges++;
            if (done) seen = 1;
        end
        chk("pz_done_seen", seen, 1);
        chk("pz_done_edge", edges, 14);

        // Stop with simultaneous start at q=4
        mode = 1'b0; limit = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        ticks(4);
        chk("ss_q4", q, 4);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("ss_q0", q, 0);
        chk("ss_idle", busy, 0);
        chk("ss_no_err", err, 0);
        tick();
        start = 1'b1; limit = 4'd3;
        tick();
        start = 1'b0;
        chk("ss_restart", busy, 1);
        ticks(5);

        // Rejected start
        start = 1'b1; limit = 4'd0;
        tick();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        tick();
        chk("rej_err_pulse", err, 0);

        // Async reset while running
        mode = 1'b1; limit = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        ticks(3);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("ar_q",       q,       0);
        chk("ar_busy",    busy,    0);
        chk("ar_done",    done,    0);
        chk("ar_err",     err,     0);
        chk("ar_periods", periods, 0);
        ticks(2);
        reset = 1'b1;
        ticks(3);
        chk("ar_stays_idle", busy, 0);

        // Period counter saturation
        mode = 1'b1; limit = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        ticks(600);
        chk("sat_periods", periods, PMAX);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            stop  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 5) == 0);
            mode  = 1'($urandom_range(0, 1));
            limit = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1; stop = 1'b0; start = 1'b0; pause = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
